// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between NUM_REQ requesters, the arbiter and the UART transmitter.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [NUM_REQ-1:0]   grant;
   logic                 busy;
   logic                 timeout;

   modport slave (
      input  req_data, req_valid, req_last, tx_ready,
      output req_ready, tx_data, tx_valid, grant, busy, timeout
   );

   modport master (
      output req_data, req_valid, req_last, tx_ready,
      input  req_ready, tx_data, tx_valid, grant, busy, timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of a UART transmitter byte port.
// Optional stall release is built only when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_arbiter_if.slave bus
);
   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t             r_state;
   logic [IW-1:0]      r_ptr;
   logic [IW-1:0]      r_owner;
   logic [NUM_REQ-1:0] r_grant;

   logic [IW-1:0]      w_pick;
   logic [IW-1:0]      w_idx;
   logic               w_any;
   logic [7:0]         w_tx_data;
   logic               w_own_valid;
   logic               w_own_last;
   logic [NUM_REQ-1:0] w_req_ready;
   logic               w_xfer;

   // Scan from the farthest offset down so the nearest valid requester after r_ptr wins last.
   always_comb begin
      w_pick = '0;
      w_any  = 1'b0;
      w_idx  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_idx = IW'((32'(r_ptr) + NUM_REQ - i) % NUM_REQ);
         if (bus.req_valid[w_idx]) begin
            w_pick = w_idx;
            w_any  = 1'b1;
         end
      end
   end

   // r_grant is all zero in IDLE, which also gives the zero outputs required there.
   always_comb begin
      w_tx_data   = '0;
      w_own_valid = 1'b0;
      w_own_last  = 1'b0;
      w_req_ready = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (r_grant[i]) begin
            w_tx_data      = bus.req_data[8*i +: 8];
            w_own_valid    = bus.req_valid[i];
            w_own_last     = bus.req_last[i];
            w_req_ready[i] = bus.tx_ready;
         end
      end
   end

   assign w_xfer = w_own_valid & bus.tx_ready;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   logic          r_timeout;
`else
   logic w_unused;
   assign w_unused = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_ptr     <= IW'(NUM_REQ - 1);
         r_owner   <= '0;
         r_grant   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         r_cnt     <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner <= w_pick;
                  r_grant <= NUM_REQ'(1) << w_pick;
                  r_state <= LOCKED;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
               end
            end
            LOCKED: begin
               if (w_xfer && w_own_last) begin
                  r_ptr   <= r_owner;
                  r_grant <= '0;
                  r_state <= IDLE;
               end
`ifdef UART_TX_ARB_TIMEOUT_EN
               else if (w_xfer) begin
                  r_cnt <= '0;
               end else if (!w_own_valid) begin
                  if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                     r_timeout <= 1'b1;
                     r_ptr     <= r_owner;
                     r_grant   <= '0;
                     r_state   <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.tx_data   = w_tx_data;
   assign bus.tx_valid  = w_own_valid;
   assign bus.req_ready = w_req_ready;
   assign bus.grant     = r_grant;
   assign bus.busy      = (r_state == LOCKED);
`ifdef UART_TX_ARB_TIMEOUT_EN
   assign bus.timeout   = r_timeout;
`else
   assign bus.timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table vectors, directed packet sequences and random traffic vs a packet-level model.
module tb_uart_tx_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_err = 0;
   int n_chk = 0;

   logic [8:0]     rq [N][$];   // per-requester pending bytes {last, data}
   logic [N-1:0]   gate;
   logic           txr;
   logic [7:0]     act_q [$];
   logic [N-1:0]   drv_v, drv_l;
   logic [N*8-1:0] drv_d;

   int   m_owner, m_ptr, m_cnt;
   logic m_to;

   logic [N-1:0] s_grant, s_ready;
   logic         s_txv, s_busy, s_to;
   logic [7:0]   s_data;

   typedef struct {
      logic         txr;
      logic [N-1:0] grant;
      logic         txv;
      logic [7:0]   data;
      logic [N-1:0] ready;
   } vec_t;
   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      drv_v = '0;
      drv_l = '0;
      drv_d = '0;
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() > 0) begin
            drv_d[8*i +: 8] = rq[i][0][7:0];
            drv_l[i]        = rq[i][0][8];
            drv_v[i]        = gate[i];
         end
      end
      bus.req_valid = drv_v;
      bus.req_last  = drv_l;
      bus.req_data  = drv_d;
      bus.tx_ready  = txr;
   endtask

   // One clock: drive at negedge, compare against model, then advance model to the next cycle.
   task automatic step();
      logic [N-1:0] eg, er;
      logic         ev;
      logic [7:0]   ed;
      int           o, nxt;
      @(negedge clk);
      drive();
      #1;
      eg = '0; er = '0; ev = 1'b0; ed = '0;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         ev          = drv_v[m_owner];
         ed          = drv_d[8*m_owner +: 8];
         er[m_owner] = txr;
      end
      s_grant = bus.grant;  s_ready = bus.req_ready; s_txv = bus.tx_valid;
      s_busy  = bus.busy;   s_to    = bus.timeout;   s_data = bus.tx_data;
      check("cycle", {13'd0, s_grant, s_busy, s_txv, s_data, s_ready, s_to},
                     {13'd0, eg, (m_owner >= 0), ev, ed, er, m_to});
      if (bus.tx_valid && bus.tx_ready) act_q.push_back(bus.tx_data);
      m_to = 1'b0;
      if (m_owner < 0) begin
         nxt = -1;
         for (int k = 1; k <= N; k++)
            if (nxt < 0 && drv_v[(m_ptr + k) % N]) nxt = (m_ptr + k) % N;
         if (nxt >= 0) begin
            m_owner = nxt;
            m_cnt   = 0;
         end
      end else begin
         o = m_owner;
         if (drv_v[o] && txr) begin
            void'(rq[o].pop_front());
            m_cnt = 0;
            if (drv_l[o]) begin
               m_ptr   = o;
               m_owner = -1;
            end
         end
`ifdef UART_TX_ARB_TIMEOUT_EN
         else if (!drv_v[o]) begin
            if (m_cnt == TO - 1) begin
               m_to    = 1'b1;
               m_ptr   = o;
               m_owner = -1;
            end else begin
               m_cnt++;
            end
         end
`endif
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_out", {13'd0, bus.grant, bus.busy, bus.tx_valid, bus.tx_data, bus.req_ready, bus.timeout}, 32'd0);
      @(negedge clk);
      for (int i = 0; i < N; i++) rq[i].delete();
      m_owner = -1; m_ptr = N - 1; m_cnt = 0; m_to = 1'b0;
      drive();
      rst_n = 1'b1;
   endtask

   task automatic check_bytes(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4, input int n);
      logic [7:0] exp [5];
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3; exp[4] = e4;
      check({name, "_count"}, act_q.size(), n);
      for (int i = 0; i < n && i < act_q.size(); i++) check({name, "_byte"}, act_q[i], exp[i]);
   endtask

   initial begin
      int   bad, cnt, len;
      logic [7:0] d1, d2;
      rst_n = 1'b0;
      gate  = '1;
      txr   = 1'b1;
      for (int i = 0; i < N; i++) rq[i].delete();
      drive();

      //                txr   grant    txv  data   ready
      tbl[0] = '{1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
      tbl[1] = '{1'b1, 4'b0001, 1'b1, 8'h41, 4'b0001};
      tbl[2] = '{1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
      tbl[3] = '{1'b1, 4'b0010, 1'b1, 8'h42, 4'b0010};
      tbl[4] = '{1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
      tbl[5] = '{1'b1, 4'b0100, 1'b1, 8'h43, 4'b0100};
      tbl[6] = '{1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
      tbl[7] = '{1'b1, 4'b1000, 1'b1, 8'h44, 4'b1000};
      tbl[8] = '{1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
      tbl[9] = '{1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};

      do_reset();

      // all four requesters with single-byte packets
      for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(8'h41 + i)});
      act_q.delete();
      for (int t = 0; t < 10; t++) begin
         txr = tbl[t].txr;
         step();
         check("tbl", {15'd0, s_grant, s_txv, s_data, s_ready},
                      {15'd0, tbl[t].grant, tbl[t].txv, tbl[t].data, tbl[t].ready});
      end
      check_bytes("rr_order", 8'h41, 8'h42, 8'h43, 8'h44, 8'h00, 4);

      // packet lock: requester 2 holds the line while requester 0 waits
      rq[1].push_back({1'b1, 8'h55});
      repeat (3) step();
      act_q.delete();
      rq[0].push_back({1'b1, 8'h30});
      rq[2].push_back({1'b0, 8'h10});
      rq[2].push_back({1'b0, 8'h11});
      rq[2].push_back({1'b1, 8'h12});
      bad = 0;
      repeat (4) begin
         step();
         if (s_ready[0]) bad++;
      end
      check("lock_ready0", bad, 0);
      repeat (3) step();
      check_bytes("lock", 8'h10, 8'h11, 8'h12, 8'h30, 8'h00, 4);

      // backpressure: tx_ready 1,0,0,1 inside one packet
      act_q.delete();
      rq[1].push_back({1'b0, 8'h20});
      rq[1].push_back({1'b0, 8'h21});
      rq[1].push_back({1'b1, 8'h22});
      txr = 1'b1; step(); step();
      txr = 1'b0; step(); d1 = s_data; check("bp_ready_lo", s_ready, 0);
      step(); d2 = s_data; check("bp_ready_lo", s_ready, 0);
      check("bp_hold1", d1, 8'h21);
      check("bp_hold2", d2, 8'h21);
      txr = 1'b1; step(); step(); step();
      check_bytes("bp", 8'h20, 8'h21, 8'h22, 8'h00, 8'h00, 3);

      // reset in the middle of a 4-byte packet
      for (int b = 0; b < 4; b++) rq[2].push_back({(b == 3), 8'(8'h60 + b)});
      repeat (3) step();
      do_reset();
      rq[0].push_back({1'b1, 8'h70});
      rq[3].push_back({1'b1, 8'h73});
      step(); step();
      check("post_reset_grant", s_grant, 4'b0001);
      repeat (3) step();

`ifdef UART_TX_ARB_TIMEOUT_EN
      // owner stalls with valid low: forced release after TO cycles
      rq[1].push_back({1'b0, 8'h80});
      rq[1].push_back({1'b1, 8'h81});
      step(); step();
      rq[2].push_back({1'b1, 8'h90});
      gate[1] = 1'b0;
      cnt = -1;
      for (int t = 0; t < 50 && cnt < 0; t++) begin
         step();
         if (s_to) cnt = t;
      end
      check("to_delay", cnt, TO);
      check("to_idle", s_busy, 1'b0);
      step();
      check("to_next_grant", s_grant, 4'b0100);
      step(); step();
      rq[1].delete();
      gate[1] = 1'b1;
      // owner valid but UART busy: must not time out
      rq[3].push_back({1'b0, 8'hA0});
      rq[3].push_back({1'b1, 8'hA1});
      txr = 1'b0;
      step();
      bad = 0;
      repeat (20) begin
         step();
         if (s_to || !s_busy) bad++;
      end
      check("no_to_when_busy", bad, 0);
      txr = 1'b1;
      repeat (3) step();
`else
      // owner stalls with valid low: grant held indefinitely
      act_q.delete();
      rq[1].push_back({1'b0, 8'h80});
      rq[1].push_back({1'b1, 8'h81});
      rq[2].push_back({1'b1, 8'h90});
      step(); step();
      gate[1] = 1'b0;
      bad = 0;
      repeat (1000) begin
         step();
         if (s_to || !s_busy || s_grant != 4'b0010) bad++;
      end
      check("stall_hold", bad, 0);
      gate[1] = 1'b1;
      repeat (5) step();
      check_bytes("stall", 8'h80, 8'h81, 8'h90, 8'h00, 8'h00, 3);
`endif

      // random traffic against the model
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < N; i++) begin
            if (rq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) rq[i].push_back({(b == len - 1), 8'($urandom)});
            end
            gate[i] = ($urandom_range(0, 7) != 0);
         end
         txr = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-locked round-robin arbiter that shares one UART transmitter byte interface among `NUM_REQ` byte-stream requesters (debug console, Ethernet status reporter, etc.). Sits directly upstream of the UART transmitter. Holds the grant for a whole packet (through the byte flagged `last`) so messages from different sources never interleave on the serial line.

## Interface
- `NUM_REQ`, 4, number of requesters; legal range 2..16.
- `TIMEOUT_CYCLES`, 65535, stall limit used only when `UART_TX_ARB_TIMEOUT_EN` is defined; must be ≥ 2.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_data`  in  NUM_REQ*8  byte from requester i at bits [8*i +: 8].
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_last`  in  NUM_REQ  byte from requester i is the final byte of its packet.
- `req_ready`  out  NUM_REQ  byte from requester i accepted this cycle when also valid.
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_valid`  out  1  byte to the UART transmitter is valid.
- `tx_ready`  in  1  UART transmitter accepts a byte.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `busy`  out  1  a packet is in progress (state LOCKED).
- `timeout`  out  1  one-cycle pulse when a stalled grant is forcibly released.

## Operation
- States: IDLE, LOCKED.
- IDLE: `grant`=0, `tx_valid`=0, `req_ready`=0. If any `req_valid` is high, select the first requester with valid set, scanning from `ptr+1` upward and wrapping modulo NUM_REQ. Register it in `grant`, then move to LOCKED.
- LOCKED with owner g:
  - `tx_data` = `req_data[g]`, `tx_valid` = `req_valid[g]`, `req_ready[g]` = `tx_ready`; the other `req_ready` bits are 0. The path is combinational with no buffering.
  - A transfer occurs when `req_valid[g] & tx_ready`.
  - On a transfer with `req_last[g]`=1: set `ptr` ← g, clear `grant`, go to IDLE.
  - Transfers without `last` stay in LOCKED.
- `ptr` resets to NUM_REQ-1, so requester 0 wins the first arbitration.
- Requests from non-owners are ignored while LOCKED. They are never dropped; they wait for the next IDLE arbitration.
- A requester that drops `req_valid` before being granted loses nothing. Arbitration only samples the current cycle.
- A single-byte packet (`valid` and `last` on the first byte) is legal: LOCKED lasts until that byte transfers.
- Reset mid-packet: all state clears immediately, giving IDLE, `grant`=0 and `ptr`=NUM_REQ-1. The partial packet is abandoned, and the requester must restart it.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `req_ready`=0, `grant`=0, `busy`=0, `timeout`=0.
- Arbitration latency: a request in IDLE at cycle N yields `grant`/`busy` at N+1. The first byte can transfer at N+1.
- The byte path adds zero cycles of latency from `req_*` to `tx_*` and from `tx_ready` to `req_ready`.
- Gap between packets: the cycle after the last byte transfers is always IDLE. The next owner is granted one cycle later, so there is exactly one dead cycle per packet boundary.
- `tx_valid` never deasserts while `req_valid[g]` is held, and `tx_data` is stable until accepted, provided the requester obeys valid/ready.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in LOCKED.
  - It increments each cycle that `req_valid[g]`=0 and clears on any transfer and on entry to LOCKED.
  - Cycles with `req_valid[g]`=1 and `tx_ready`=0 (UART busy) do not count.
  - When the counter reaches TIMEOUT_CYCLES-1 with `req_valid[g]` still 0: pulse `timeout` for one cycle, set `ptr` ← g, go to IDLE.
- Not defined: no counter is built, `timeout` is tied to 0, and LOCKED is held indefinitely until `last`.

## Test plan
- Reset, then assert `req_valid`=4'b1111, each with a 1-byte packet (0x41, 0x42, 0x43, 0x44), `tx_ready`=1 → tx bytes in order 0x41, 0x42, 0x43, 0x44; `grant` sequence 0001, 0010, 0100, 1000 with one idle cycle between each.
- Requester 2 sends 3-byte packet 0x10, 0x11, 0x12 (last on 0x12) while requester 0 is valid throughout → all three bytes from requester 2 go out before any requester-0 byte; `req_ready[0]` stays 0 for the whole packet.
- Grant held, `tx_ready` toggling 1,0,0,1 → `tx_data` is unchanged while `tx_ready`=0, no duplicate bytes, `req_ready[g]` mirrors `tx_ready` exactly.
- Assert `rst_n`=0 after byte 2 of a 4-byte packet → `grant`=0, `busy`=0, `tx_valid`=0 immediately. After release, requester 0 has first priority again.
- With `UART_TX_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=8: owner drops valid mid-packet → `timeout` pulses 8 cycles after valid drops, then IDLE, and the next requester is granted one cycle later. Repeat with `tx_ready`=0 and owner valid for 20 cycles → no timeout.
- Without the macro, repeat the stall for 1000 cycles → `busy` stays 1 and `timeout` stays 0.
